// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - pushbutton synchroniser, debouncer and auto-repeat strobe generator
module button_conditioner #(
    parameter int NUM_BTN         = 3,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_pad,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    // Debounce counter holds 1..DEBOUNCE_CYCLES and is never incremented past the top.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEBOUNCE_CYCLES);

    // Repeat counter: a strobe fires on the cycle it would reach REPEAT_DELAY, so the
    // stored value tops out at REPEAT_DELAY-1 and then reloads to keep the REPEAT_RATE phase.
    localparam bit REPEAT_EN = (REPEAT_DELAY > 0);
    localparam int RPT_MAX   = REPEAT_EN ? REPEAT_DELAY : 1;
    localparam int RCNT_W    = $clog2(RPT_MAX + 1);
    localparam int RELOAD_I  = (REPEAT_RATE >= RPT_MAX) ? 0 : (RPT_MAX - REPEAT_RATE);
    localparam logic [RCNT_W-1:0] RCNT_LAST   = RCNT_W'(RPT_MAX - 1);
    localparam logic [RCNT_W-1:0] RCNT_RELOAD = RCNT_W'(RELOAD_I);

    // Synchroniser reset value is the pad level of a released button.
    localparam logic [NUM_BTN-1:0] PAD_RELEASED = {NUM_BTN{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } state_t;

    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;

    // Two-flop synchroniser for the asynchronous pads, all channels together.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= PAD_RELEASED;
            sync2_q <= PAD_RELEASED;
        end else begin
            sync1_q <= btn_pad;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        logic              p;
        state_t            state_q;
        state_t            state_d;
        logic [CNT_W-1:0]  cnt_q;
        logic [CNT_W-1:0]  cnt_d;
        logic [RCNT_W-1:0] rcnt_q;
        logic [RCNT_W-1:0] rcnt_d;
        logic              press_d;
        logic              release_d;
        logic              repeat_d;
        logic              level_d;
        logic              level_q;
        logic              press_q;
        logic              release_q;
        logic              repeat_q;

        // Polarity-normalised synchronised sample, 1 = pressed.
        assign p = ACTIVE_LOW ? ~sync2_q[g] : sync2_q[g];

        // State and counter registers; reset aborts any debounce or hold in progress.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                rcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rcnt_q  <= rcnt_d;
            end
        end

        // Next-state, counter updates and strobe decisions for this channel.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            rcnt_d    = rcnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            repeat_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (p) begin
                        state_d = DB_PRESS;
                        cnt_d   = CNT_ONE;
                    end
                end
                DB_PRESS: begin
                    if (!p) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_TOP) begin
                        state_d = HELD;
                        rcnt_d  = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!p) begin
                        state_d = DB_REL;
                        cnt_d   = CNT_ONE;
                    end else if (REPEAT_EN) begin
                        if (rcnt_q == RCNT_LAST) begin
                            rcnt_d   = RCNT_RELOAD;
                            press_d  = 1'b1;
                            repeat_d = 1'b1;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                end
                DB_REL: begin
                    // A bounce back to pressed returns to HELD with the repeat phase intact.
                    if (p) begin
                        state_d = HELD;
                    end else if (cnt_q == CNT_TOP) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            level_d = (state_d == HELD) || (state_d == DB_REL);
        end

        // Registered outputs, launched on the same edge as the state transition.
        always_ff @(posedge clk) begin
            if (reset) begin
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                repeat_q  <= repeat_d;
            end
        end

        assign btn_level[g]   = level_q;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = release_q;
        assign btn_repeat[g]  = repeat_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed and randomized bench for button_conditioner
module tb_button_conditioner;

    localparam int NB    = 3;
    localparam bit ALOW  = 1'b1;
    localparam int DC    = 4;
    localparam int DELAY = 10;
    localparam int RATE  = 3;
    localparam logic [NB-1:0] REL = {NB{ALOW}};

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_pad;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_repeat;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pad delay line, accepted level, length of the current run of
    // samples disagreeing with that level, and count of pressed samples spent held.
    logic [NB-1:0] m_d1;
    logic [NB-1:0] m_d2;
    logic [NB-1:0] m_lvl;
    int            m_run  [NB];
    int            m_held [NB];
    logic [NB-1:0] exp_level   = '0;
    logic [NB-1:0] exp_press   = '0;
    logic [NB-1:0] exp_release = '0;
    logic [NB-1:0] exp_repeat  = '0;

    button_conditioner #(
        .NUM_BTN         (NB),
        .ACTIVE_LOW      (ALOW),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (DELAY),
        .REPEAT_RATE     (RATE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_pad     (btn_pad),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    always #5 clk = ~clk;

    function automatic bit repeat_due(input int h);
        if (DELAY == 0) return 1'b0;
        if (h == DELAY) return 1'b1;
        return (h > DELAY) && (((h - DELAY) % RATE) == 0);
    endfunction

    task automatic model_edge();
        logic [NB-1:0] p;
        exp_press   = '0;
        exp_release = '0;
        exp_repeat  = '0;
        if (reset) begin
            m_d1  = REL;
            m_d2  = REL;
            m_lvl = '0;
            for (int i = 0; i < NB; i++) begin
                m_run[i]  = 0;
                m_held[i] = 0;
            end
            exp_level = '0;
            return;
        end
        p    = ALOW ? ~m_d2 : m_d2;
        m_d2 = m_d1;
        m_d1 = btn_pad;
        for (int i = 0; i < NB; i++) begin
            if (p[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DC + 1) begin
                    m_lvl[i] = p[i];
                    m_run[i] = 0;
                    if (p[i]) begin
                        exp_press[i] = 1'b1;
                        m_held[i]    = 0;
                    end else begin
                        exp_release[i] = 1'b1;
                    end
                end
            end else begin
                if (m_lvl[i] && m_run[i] == 0) begin
                    m_held[i]++;
                    if (repeat_due(m_held[i])) begin
                        exp_press[i]  = 1'b1;
                        exp_repeat[i] = 1'b1;
                    end
                end
                m_run[i] = 0;
            end
        end
        exp_level = m_lvl;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("level",   32'(btn_level),   32'(exp_level));
        chk("press",   32'(btn_press),   32'(exp_press));
        chk("release", 32'(btn_release), 32'(exp_release));
        chk("repeat",  32'(btn_repeat),  32'(exp_repeat));
    endtask

    initial begin
        int cnt;
        reset   = 1'b1;
        btn_pad = REL;
        tick();
        tick();
        chk("reset_outputs", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'd0);
        reset = 1'b0;
        repeat (3) tick();

        // Clean press on channel 0: strobe only in cycle 6, level from cycle 6.
        btn_pad[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("c1_press", 32'(btn_press[0]), 32'(k == 6));
            chk("c1_level", 32'(btn_level[0]), 32'(k >= 6));
        end

        // Release: strobe and level fall together in cycle 6.
        btn_pad[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("c3_release", 32'(btn_release[0]), 32'(k == 6));
            chk("c3_level",   32'(btn_level[0]),   32'(k < 6));
        end

        // Bounce then steady press: exactly one press strobe.
        cnt = 0;
        btn_pad[0] = 1'b0; tick(); cnt += int'(btn_press[0]);
        btn_pad[0] = 1'b1; tick(); cnt += int'(btn_press[0]);
        btn_pad[0] = 1'b0; tick(); cnt += int'(btn_press[0]);
        btn_pad[0] = 1'b1; tick(); cnt += int'(btn_press[0]);
        btn_pad[0] = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            cnt += int'(btn_press[0]);
        end
        chk("c2_press_count", 32'(cnt), 32'd1);
        btn_pad[0] = 1'b1;
        repeat (10) tick();

        // Auto-repeat on channel 1 at held cycles 10, 13, 16, ...
        cnt = 0;
        btn_pad[1] = 1'b0;
        for (int k = 0; k <= 36; k++) begin
            tick();
            cnt += int'(btn_repeat[1]);
            chk("c4_repeat", 32'(btn_repeat[1]), 32'(k >= 16 && ((k - 16) % 3) == 0));
            chk("c4_press",  32'(btn_press[1]),  32'(k == 6 || (k >= 16 && ((k - 16) % 3) == 0)));
        end
        chk("c4_repeat_count", 32'(cnt), 32'd7);

        // Release glitch of two cycles while held: no release, level stays up.
        btn_pad[1] = 1'b1; tick();
        chk("c5_level_g", 32'(btn_level[1]), 32'd1);
        tick();
        chk("c5_level_g", 32'(btn_level[1]), 32'd1);
        btn_pad[1] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("c5_release", 32'(btn_release[1]), 32'd0);
            chk("c5_level",   32'(btn_level[1]),   32'd1);
        end
        btn_pad[1] = 1'b1;
        repeat (10) tick();

        // Reset during DB_PRESS on channel 2 forces a fresh debounce period.
        btn_pad[2] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("c6_reset_outputs", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("c6_press", 32'(btn_press[2]), 32'(k == 6));
        end
        btn_pad[2] = 1'b1;
        repeat (10) tick();

        // Simultaneous presses on all channels strobe together.
        btn_pad = ~REL;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("sim_press", 32'(btn_press), (k == 6) ? 32'h7 : 32'h0);
        end
        btn_pad = REL;
        repeat (10) tick();

        // Randomized pad activity with occasional resets, checked against the model.
        for (int s = 0; s < 80; s++) begin
            btn_pad = NB'($urandom);
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            repeat ($urandom_range(1, 14)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
